minisrc_control_unit: RTL

- Hardwired Moore control sequencer for the miniSRC datapath.
- Replaces hand-driven testbench control with an FSM that fetches an instruction and decodes IR[31:27].
- Sequences the register-file, Y/Z, MAR/MDR, PC/IR and I/O strobes for ALU-register, ALU-immediate, ld/ldi/st, in/out, nop and halt.
- Sits beside the miniSRC datapath; its outputs connect one-to-one to the datapath control inputs.

---
 rtl/minisrc_control_unit_pkg.sv | 34 +++
 rtl/minisrc_control_unit_op_to_aluop.sv | 17 +
 rtl/minisrc_control_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/minisrc_control_unit_pkg.sv
// minisrc_ctrl_pkg: shared types and constants for the miniSRC control unit.
// Holds the sequencer state enum, instruction opcodes (IR[31:27]) and ALU
// operation codes driven onto the datapath opcode bus.
package minisrc_ctrl_pkg;

    typedef enum logic [3:0] {RST, T0, T1, FW, T2, T3, T4, T5, T6, T7, MW, HALT} state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b01010;
    localparam logic [4:0] ALU_OR  = 5'b01011;
    localparam logic [4:0] ALU_NOP = 5'b11010;

    function automatic logic op_defined(input logic [4:0] op);
        return op inside {OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
                          OP_ADDI, OP_ANDI, OP_ORI, OP_IN, OP_OUT, OP_NOP, OP_HALT};
    endfunction

endpackage

// File: rtl/minisrc_control_unit_op_to_aluop.sv
// op_to_aluop: maps an instruction opcode to the ALU operation used in its execute step.
// Ports: op_i  instruction opcode (IR[31:27]); alu_o  ALU operation select.
// Address arithmetic for ld/ldi/st uses ALU_ADD; anything else yields ALU_NOP.
module op_to_aluop
    import minisrc_ctrl_pkg::*;
(
    input  logic [4:0] op_i,
    output logic [4:0] alu_o
);

    always_comb
        alu_o = (op_i inside {OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST}) ? ALU_ADD :
                (op_i == OP_SUB)                                      ? ALU_SUB :
                (op_i inside {OP_AND, OP_ANDI})                       ? ALU_AND :
                (op_i inside {OP_OR, OP_ORI})                         ? ALU_OR  : ALU_NOP;

endmodule

// File: rtl/minisrc_control_unit.sv
// minisrc_control_unit: hardwired Moore sequencer driving the miniSRC datapath strobes.
// Ports: clock/clear (async active-low reset), ir_opcode (IR[31:27], used in T3),
//        register-file, PC/IR, Y/Z, memory and I/O strobes, ALU opcode, run,
//        and illegal when CU_ILLEGAL_TRAP_EN is defined (undefined opcodes trap to HALT).
// MEM_WAIT sets how many extra cycles each memory access is held (FW/MW states).
module minisrc_control_unit
    import minisrc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [4:0] ir_opcode,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       BAout,
    output logic       PCout_en,
    output logic       IncPC,
    output logic       PC_en,
    output logic       IR_en,
    output logic       Yin,
    output logic       Zin,
    output logic       Zlowout,
    output logic       Cout,
    output logic       MDRout,
    output logic       MDRin,
    output logic       MARin,
    output logic       memRead,
    output logic       memWrite,
    output logic       inPortOut,
    output logic       outPort_en,
    output logic [4:0] opcode,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic       run
);

    localparam int CW = MEM_WAIT > 0 ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(MEM_WAIT > 0 ? MEM_WAIT - 1 : 0);
    localparam logic HAS_WAIT = MEM_WAIT > 0;

    state_t state_q, state_d;
    logic [4:0] op_q, op, alu_op;
    logic [CW-1:0] cnt_q;
    logic t0, t1, fw, t2, t3, t4, t5, t6, t7, mw;
    logic is_imm, is_reg, is_ldi, is_ld, is_st, is_in, is_out, is_halt, wb, exe, mem, trap;

    // IR is only loaded at the end of T2, so T3 decodes the live field before op_q captures it.
    assign op = (state_q == T3) ? ir_opcode : op_q;

    assign is_imm  = op inside {OP_ADDI, OP_ANDI, OP_ORI};
    assign is_reg  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    assign is_ldi  = op == OP_LDI;
    assign is_ld   = op == OP_LD;
    assign is_st   = op == OP_ST;
    assign is_in   = op == OP_IN;
    assign is_out  = op == OP_OUT;
    assign is_halt = op == OP_HALT;
    assign wb      = is_imm | is_reg | is_ldi;
    assign mem     = is_ld | is_st;
    assign exe     = wb | mem;
`ifdef CU_ILLEGAL_TRAP_EN
    assign trap    = !op_defined(op);
`else
    assign trap    = 1'b0;
`endif

    op_to_aluop u_aluop (.op_i(op_q), .alu_o(alu_op));

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:     state_d = T0;
            T0:      state_d = T1;
            T1:      state_d = HAS_WAIT ? FW : T2;
            FW:      state_d = cnt_q == '0 ? T2 : FW;
            T2:      state_d = T3;
            T3:      state_d = exe ? T4 : (is_halt | trap) ? HALT : T0;
            T4:      state_d = T5;
            T5:      state_d = mem ? T6 : T0;
            T6:      state_d = (is_ld && HAS_WAIT) ? MW : T7;
            T7:      state_d = (is_st && HAS_WAIT) ? MW : T0;
            MW:      state_d = cnt_q != '0 ? MW : is_ld ? T7 : T0;
            HALT:    state_d = HALT;
            default: state_d = RST;
        endcase
    end

    always_ff @(posedge clock or negedge clear)
        if (!clear) begin
            state_q <= RST;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T3) op_q <= ir_opcode;
            // Reload only on entry so the wait state counts MEM_WAIT cycles down to zero.
            cnt_q <= (state_d inside {FW, MW} && !(state_q inside {FW, MW})) ? RELOAD :
                     (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clock or negedge clear)
        if (!clear) illegal_q <= 1'b0;
        else if (state_q == T3 && trap) illegal_q <= 1'b1;
    assign illegal = illegal_q;
`endif

    assign t0 = state_q == T0;
    assign t1 = state_q == T1;
    assign fw = state_q == FW;
    assign t2 = state_q == T2;
    assign t3 = state_q == T3;
    assign t4 = state_q == T4;
    assign t5 = state_q == T5;
    assign t6 = state_q == T6;
    assign t7 = state_q == T7;
    assign mw = state_q == MW;

    assign Gra        = (t3 & (is_in | is_out)) | (t5 & wb) | (t6 & is_st) | (t7 & is_ld);
    assign Grb        = t3 & exe;
    assign Grc        = t4 & is_reg;
    assign Rin        = (t3 & is_in) | (t5 & wb) | (t7 & is_ld);
    assign Rout       = (t3 & (is_imm | is_reg | is_out)) | (t4 & is_reg) | (t6 & is_st);
    assign BAout      = t3 & (is_ldi | mem);
    assign PCout_en   = t0;
    assign IncPC      = t0;
    assign PC_en      = t1;
    assign IR_en      = t2;
    assign Yin        = t3 & exe;
    assign Zin        = t0 | (t4 & exe);
    assign Zlowout    = t1 | (t5 & exe);
    assign Cout       = t4 & (is_imm | is_ldi | mem);
    assign MDRout     = t2 | (t7 & is_ld);
    assign MDRin      = t1 | fw | (t6 & mem) | (mw & is_ld);
    assign MARin      = t0 | (t5 & mem);
    assign memRead    = t1 | fw | (is_ld & (t6 | mw));
    assign memWrite   = is_st & (t7 | mw);
    assign inPortOut  = t3 & is_in;
    assign outPort_en = t3 & is_out;
    assign opcode     = t4 ? alu_op : ALU_NOP;
    assign run        = state_q != HALT;

endmodule
